// File: rtl/mem_beat_sequencer.sv
// Splits RV32I byte/half/word loads and stores into 16-bit SDRAM beats and
// assembles the load result; one request in flight at a time.
//
// state  | meaning
// IDLE   | ready for a new request
// ISSUE0 | first beat presented to the SDRAM controller
// WAIT0  | first read beat accepted, waiting for its halfword
// ISSUE1 | second beat of a word access presented
// WAIT1  | second read beat accepted, waiting for its halfword
// RESP   | one-cycle completion pulse
module mem_beat_sequencer #(
    parameter int ADDR_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [2:0]        req_funct3,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              sd_valid,
    input  logic              sd_ready,
    output logic              sd_we,
    output logic [ADDR_W-1:0] sd_addr,
    output logic [15:0]       sd_wdata,
    output logic [1:0]        sd_dqm,
    input  logic              sd_rvalid,
    input  logic [15:0]       sd_rdata
);

    typedef enum logic [2:0] {IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   addr_q, addr_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              err_q, err_d;
    logic [15:0]       beat0_q, beat0_d;
    logic [15:0]       beat1_q, beat1_d;

    logic              req_bad;
    logic              is_word;
    logic [7:0]        ld_byte;
    logic              unused_addr_hi;

    // Byte address bits above the SDRAM halfword space are not routed anywhere.
    assign unused_addr_hi = ^req_addr[31:ADDR_W+1];
    assign is_word        = (funct3_q[1:0] == 2'b10);

    always_comb begin
        req_bad = 1'b0;
        case (req_funct3)
            3'b000, 3'b100: req_bad = 1'b0;
            3'b001, 3'b101: req_bad = req_addr[0];
            3'b010:         req_bad = |req_addr[1:0];
            default:        req_bad = 1'b1;
        endcase
        if (req_we && req_funct3[2]) req_bad = 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        funct3_d = funct3_q;
        err_d    = err_q;
        beat0_d  = beat0_q;
        beat1_d  = beat1_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d   = req_addr[ADDR_W:0];
                    we_d     = req_we;
                    wdata_d  = req_wdata;
                    funct3_d = req_funct3;
                    err_d    = req_bad;
                    state_d  = req_bad ? RESP : ISSUE0;
                end
            end
            ISSUE0: begin
                if (sd_ready) begin
                    if (!we_q)        state_d = WAIT0;
                    else if (is_word) state_d = ISSUE1;
                    else              state_d = RESP;
                end
            end
            WAIT0: begin
                if (sd_rvalid) begin
                    beat0_d = sd_rdata;
                    state_d = is_word ? ISSUE1 : RESP;
                end
            end
            ISSUE1: begin
                if (sd_ready) state_d = we_q ? RESP : WAIT1;
            end
            WAIT1: begin
                if (sd_rvalid) begin
                    beat1_d = sd_rdata;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            funct3_q <= '0;
            err_q    <= 1'b0;
            beat0_q  <= '0;
            beat1_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            funct3_q <= funct3_d;
            err_q    <= err_d;
            beat0_q  <= beat0_d;
            beat1_q  <= beat1_d;
        end
    end

    always_comb begin
        req_ready  = (state_q == IDLE);
        sd_valid   = 1'b0;
        sd_we      = 1'b0;
        sd_addr    = '0;
        sd_wdata   = '0;
        sd_dqm     = 2'b11;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        ld_byte    = addr_q[0] ? beat0_q[15:8] : beat0_q[7:0];

        if (state_q == ISSUE0 || state_q == ISSUE1) begin
            sd_valid = 1'b1;
            sd_we    = we_q;
            sd_addr  = (state_q == ISSUE1) ? addr_q[ADDR_W:1] + ADDR_W'(1) : addr_q[ADDR_W:1];
            case (funct3_q[1:0])
                2'b00: begin
                    // Byte stores replicate onto both lanes; the mask picks the live one.
                    sd_wdata = {wdata_q[7:0], wdata_q[7:0]};
                    sd_dqm   = addr_q[0] ? 2'b01 : 2'b10;
                end
                2'b01: begin
                    sd_wdata = wdata_q[15:0];
                    sd_dqm   = 2'b00;
                end
                default: begin
                    sd_wdata = (state_q == ISSUE1) ? wdata_q[31:16] : wdata_q[15:0];
                    sd_dqm   = 2'b00;
                end
            endcase
        end

        if (state_q == RESP) begin
            resp_valid = 1'b1;
            resp_err   = err_q;
            if (!err_q && !we_q) begin
                case (funct3_q)
                    3'b000:  resp_rdata = {{24{ld_byte[7]}}, ld_byte};
                    3'b100:  resp_rdata = {24'b0, ld_byte};
                    3'b001:  resp_rdata = {{16{beat0_q[15]}}, beat0_q};
                    3'b101:  resp_rdata = {16'b0, beat0_q};
                    3'b010:  resp_rdata = {beat1_q, beat0_q};
                    default: resp_rdata = '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_beat_sequencer.sv
// Bench for mem_beat_sequencer: directed vector table, randomized transactions
// against a behavioural model, and reset-in-flight sequence.
module tb_mem_beat_sequencer;

    localparam int AW = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_we;
    logic [31:0]   req_addr, req_wdata;
    logic [2:0]    req_funct3;
    logic          resp_valid, resp_err;
    logic [31:0]   resp_rdata;
    logic          sd_valid, sd_ready, sd_we, sd_rvalid;
    logic [AW-1:0] sd_addr;
    logic [15:0]   sd_wdata, sd_rdata;
    logic [1:0]    sd_dqm;

    mem_beat_sequencer #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .sd_valid(sd_valid), .sd_ready(sd_ready), .sd_we(sd_we), .sd_addr(sd_addr),
        .sd_wdata(sd_wdata), .sd_dqm(sd_dqm), .sd_rvalid(sd_rvalid), .sd_rdata(sd_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [15:0] r0, r1;
        int          rw, vw;
        logic        err;
        logic [31:0] rdata;
        int          lat, nb;
        logic [23:0] a0, a1;
        logic [1:0]  dqm;
        logic [15:0] wd0, wd1;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    // observed transaction
    int          got_nb, got_lat, got_unstable;
    logic        got_err, got_timeout, got_rdy_resp, got_acc_rdy;
    logic [31:0] got_rdata;
    logic [23:0] got_addr [2];
    logic [1:0]  got_dqm  [2];
    logic [15:0] got_wd   [2];
    logic        got_we   [2];

    // expected transaction
    logic        m_we, m_err;
    int          m_nb, m_lat;
    logic [31:0] m_rdata;
    logic [23:0] m_addr [2];
    logic [1:0]  m_dqm  [2];
    logic [15:0] m_wd   [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, " req_ready"},  32'(req_ready), 32'd1);
        chk({tag, " sd_valid"},   32'(sd_valid), 32'd0);
        chk({tag, " sd_we"},      32'(sd_we), 32'd0);
        chk({tag, " sd_addr"},    32'(sd_addr), 32'd0);
        chk({tag, " sd_wdata"},   32'(sd_wdata), 32'd0);
        chk({tag, " sd_dqm"},     32'(sd_dqm), 32'd3);
        chk({tag, " resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, " resp_rdata"}, resp_rdata, 32'd0);
        chk({tag, " resp_err"},   32'(resp_err), 32'd0);
    endtask

    // Behavioural reference: derives beats, result and latency from the access rules.
    task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] f3, input logic [15:0] r0, input logic [15:0] r1,
                         input int rw, input int vw);
        int size, b, h;
        logic [23:0] hw;
        m_we = we;
        m_err = (f3 == 3 || f3 == 6 || f3 == 7) || (we && f3 >= 4) ||
                ((f3 == 1 || f3 == 5) && addr[0]) || (f3 == 2 && addr % 4 != 0);
        m_rdata = 0;
        m_addr[0] = 0; m_addr[1] = 0; m_dqm[0] = 0; m_dqm[1] = 0; m_wd[0] = 0; m_wd[1] = 0;
        if (m_err) begin
            m_nb  = 0;
            m_lat = 1;
        end else begin
            size = f3 % 4;
            m_nb = (size == 2) ? 2 : 1;
            hw = 24'(addr / 2);
            m_addr[0] = hw;
            m_addr[1] = hw + 24'd1;
            if (size == 0) begin
                m_dqm[0] = (addr % 2 == 1) ? 2'b01 : 2'b10;
                m_wd[0]  = 16'((wdata % 256) * 257);
            end else begin
                m_wd[0] = 16'(wdata % 65536);
                m_wd[1] = 16'(wdata / 65536);
            end
            if (!we) begin
                b = (addr % 2 == 1) ? int'(r0) / 256 : int'(r0) % 256;
                h = int'(r0);
                case (f3)
                    3'd0: m_rdata = (b >= 128) ? 32'(b - 256) : 32'(b);
                    3'd4: m_rdata = 32'(b);
                    3'd1: m_rdata = (h >= 32768) ? 32'(h - 65536) : 32'(h);
                    3'd5: m_rdata = 32'(h);
                    default: m_rdata = 32'(int'(r1) * 65536 + int'(r0));
                endcase
            end
            m_lat = 1 + m_nb * (1 + rw) + (we ? 0 : m_nb * (1 + vw));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drives one request and plays the SDRAM controller: rw stall cycles per beat,
    // read data vw cycles after each read beat, stray ready/rvalid where they must be ignored.
    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] f3, input logic [15:0] r0, input logic [15:0] r1,
                          input int rw, input int vw);
        int c, stall, rvc;
        bit in_beat, pend, done;
        logic [42:0] snap;
        got_nb = 0; got_unstable = 0; got_timeout = 0; got_rdy_resp = 1'b1;
        got_err = 1'b0; got_rdata = 0; got_lat = 0;
        stall = 0; rvc = 0; snap = '0;
        @(negedge clk);
        got_acc_rdy = req_ready;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
        sd_ready = 1'($urandom); sd_rvalid = 1'($urandom); sd_rdata = 16'($urandom);
        c = 0; in_beat = 0; pend = 0; done = 0;
        while (!done) begin
            @(negedge clk);
            c++;
            req_addr = $urandom; req_wdata = $urandom; req_we = 1'($urandom); req_funct3 = 3'($urandom);
            if (resp_valid) begin
                got_lat = c; got_rdata = resp_rdata; got_err = resp_err; got_rdy_resp = req_ready;
                sd_ready = 1'($urandom); sd_rvalid = 1'($urandom);
                done = 1;
            end else if (c > 60) begin
                got_timeout = 1'b1;
                done = 1;
            end else begin
                sd_ready  = 1'b0;
                sd_rdata  = 16'($urandom);
                sd_rvalid = pend ? 1'b0 : 1'($urandom);
                if (pend) begin
                    if (rvc == 0) begin
                        sd_rvalid = 1'b1;
                        sd_rdata  = (got_nb == 1) ? r0 : r1;
                        pend = 0;
                    end else rvc--;
                end
                if (sd_valid) begin
                    if (!in_beat) begin
                        in_beat = 1; stall = 0;
                        snap = {sd_we, sd_addr, sd_wdata, sd_dqm};
                        if (got_nb < 2) begin
                            got_addr[got_nb] = sd_addr; got_dqm[got_nb] = sd_dqm;
                            got_wd[got_nb] = sd_wdata; got_we[got_nb] = sd_we;
                        end
                    end else if ({sd_we, sd_addr, sd_wdata, sd_dqm} !== snap) got_unstable++;
                    if (stall >= rw) begin
                        sd_ready = 1'b1; in_beat = 0; got_nb++;
                        if (!we) begin pend = 1; rvc = vw; end
                    end else stall++;
                end else sd_ready = 1'($urandom);
            end
        end
    endtask

    task automatic check_txn(input string nm);
        chk({nm, " accept_ready"}, 32'(got_acc_rdy), 32'd1);
        chk({nm, " timeout"}, 32'(got_timeout), 32'd0);
        chk({nm, " resp_err"}, 32'(got_err), 32'(m_err));
        chk({nm, " resp_rdata"}, got_rdata, m_rdata);
        chk({nm, " latency"}, 32'(got_lat), 32'(m_lat));
        chk({nm, " beats"}, 32'(got_nb), 32'(m_nb));
        chk({nm, " ready_in_resp"}, 32'(got_rdy_resp), 32'd0);
        chk({nm, " stable"}, 32'(got_unstable), 32'd0);
        for (int i = 0; i < 2; i++) begin
            if (i < m_nb && i < got_nb) begin
                chk($sformatf("%s beat%0d addr", nm, i), 32'(got_addr[i]), 32'(m_addr[i]));
                chk($sformatf("%s beat%0d dqm", nm, i), 32'(got_dqm[i]), 32'(m_dqm[i]));
                chk($sformatf("%s beat%0d we", nm, i), 32'(got_we[i]), 32'(m_we));
                if (m_we) chk($sformatf("%s beat%0d wdata", nm, i), 32'(got_wd[i]), 32'(m_wd[i]));
            end
        end
        if (got_timeout) do_reset();
    endtask

    vec_t tbl[$];

    initial begin
        logic        we;
        logic [31:0] addr, wdata;
        logic [2:0]  f3;
        logic [15:0] r0, r1;
        int          rw, vw;

        tbl.push_back('{1'b1, 32'h0000_0103, 32'h0000_00A5, 3'b000, 16'h0, 16'h0, 0, 0,
                        1'b0, 32'h0, 2, 1, 24'h000081, 24'h0, 2'b01, 16'hA5A5, 16'h0});
        tbl.push_back('{1'b0, 32'h0000_0200, 32'h0, 3'b010, 16'h5678, 16'h1234, 0, 0,
                        1'b0, 32'h1234_5678, 5, 2, 24'h000100, 24'h000101, 2'b00, 16'h0, 16'h0});
        tbl.push_back('{1'b0, 32'h0000_0001, 32'h0, 3'b000, 16'h80FF, 16'h0, 0, 0,
                        1'b0, 32'hFFFF_FF80, 3, 1, 24'h0, 24'h0, 2'b01, 16'h0, 16'h0});
        tbl.push_back('{1'b0, 32'h0000_0001, 32'h0, 3'b100, 16'h80FF, 16'h0, 0, 0,
                        1'b0, 32'h0000_0080, 3, 1, 24'h0, 24'h0, 2'b01, 16'h0, 16'h0});
        tbl.push_back('{1'b0, 32'h0000_0003, 32'h0, 3'b001, 16'h0, 16'h0, 0, 0,
                        1'b1, 32'h0, 1, 0, 24'h0, 24'h0, 2'b00, 16'h0, 16'h0});
        tbl.push_back('{1'b0, 32'h0000_0000, 32'h0, 3'b011, 16'h0, 16'h0, 0, 0,
                        1'b1, 32'h0, 1, 0, 24'h0, 24'h0, 2'b00, 16'h0, 16'h0});
        tbl.push_back('{1'b1, 32'h01FF_FFFC, 32'hDEAD_BEEF, 3'b010, 16'h0, 16'h0, 3, 0,
                        1'b0, 32'h0, 9, 2, 24'hFFFFFE, 24'hFFFFFF, 2'b00, 16'hBEEF, 16'hDEAD});
        tbl.push_back('{1'b1, 32'h0000_0002, 32'h1234_CAFE, 3'b001, 16'h0, 16'h0, 1, 0,
                        1'b0, 32'h0, 3, 1, 24'h000001, 24'h0, 2'b00, 16'hCAFE, 16'h0});
        tbl.push_back('{1'b1, 32'h0000_0000, 32'h0, 3'b100, 16'h0, 16'h0, 0, 0,
                        1'b1, 32'h0, 1, 0, 24'h0, 24'h0, 2'b00, 16'h0, 16'h0});
        tbl.push_back('{1'b0, 32'h0000_0010, 32'h0, 3'b101, 16'h8001, 16'h0, 0, 1,
                        1'b0, 32'h0000_8001, 4, 1, 24'h000008, 24'h0, 2'b00, 16'h0, 16'h0});
        tbl.push_back('{1'b0, 32'h0000_0010, 32'h0, 3'b001, 16'h8001, 16'h0, 0, 0,
                        1'b0, 32'hFFFF_8001, 3, 1, 24'h000008, 24'h0, 2'b00, 16'h0, 16'h0});
        tbl.push_back('{1'b1, 32'h0000_0004, 32'h1234_5677, 3'b000, 16'h0, 16'h0, 0, 0,
                        1'b0, 32'h0, 2, 1, 24'h000002, 24'h0, 2'b10, 16'h7777, 16'h0});
        tbl.push_back('{1'b0, 32'h0000_0002, 32'h0, 3'b010, 16'h0, 16'h0, 0, 0,
                        1'b1, 32'h0, 1, 0, 24'h0, 24'h0, 2'b00, 16'h0, 16'h0});
        tbl.push_back('{1'b0, 32'h0000_1000, 32'h0, 3'b010, 16'hAAAA, 16'h5555, 2, 2,
                        1'b0, 32'h5555_AAAA, 13, 2, 24'h000800, 24'h000801, 2'b00, 16'h0, 16'h0});

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 0; req_wdata = 0; req_funct3 = 0;
        sd_ready = 1'b0; sd_rvalid = 1'b0; sd_rdata = 0;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;

        foreach (tbl[k]) begin
            do_txn(tbl[k].we, tbl[k].addr, tbl[k].wdata, tbl[k].f3, tbl[k].r0, tbl[k].r1,
                   tbl[k].rw, tbl[k].vw);
            m_we = tbl[k].we; m_err = tbl[k].err; m_rdata = tbl[k].rdata;
            m_lat = tbl[k].lat; m_nb = tbl[k].nb;
            m_addr[0] = tbl[k].a0; m_addr[1] = tbl[k].a1;
            m_dqm[0] = tbl[k].dqm; m_dqm[1] = tbl[k].dqm;
            m_wd[0] = tbl[k].wd0; m_wd[1] = tbl[k].wd1;
            check_txn($sformatf("vec%0d", k));
        end

        for (int n = 0; n < 200; n++) begin
            we    = 1'($urandom);
            addr  = $urandom;
            wdata = $urandom;
            if ($urandom_range(0, 9) < 8) begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010; 3: f3 = 3'b100; default: f3 = 3'b101;
                endcase
                if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            end else f3 = 3'($urandom);
            r0 = 16'($urandom); r1 = 16'($urandom);
            rw = $urandom_range(0, 2); vw = $urandom_range(0, 2);
            model(we, addr, wdata, f3, r0, r1, rw, vw);
            do_txn(we, addr, wdata, f3, r0, r1, rw, vw);
            check_txn($sformatf("rnd%0d", n));
        end

        // Reset while a read beat is outstanding, then a stale rvalid afterwards.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h40; req_funct3 = 3'b010;
        sd_ready = 1'b1; sd_rvalid = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        chk("midreset issue sd_valid", 32'(sd_valid), 32'd1);
        @(negedge clk);
        sd_ready = 1'b0;
        chk("midreset waiting sd_valid", 32'(sd_valid), 32'd0);
        rst = 1'b1;
        #1;
        check_reset_vals("midreset");
        @(negedge clk);
        rst = 1'b0;
        sd_rvalid = 1'b1; sd_rdata = 16'hBEEF;
        @(negedge clk);
        sd_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_reset_vals($sformatf("postreset%0d", i));
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
